letc_core_fetch_seq: RTL and testbench
======================================

// Module: letc_core_fetch_seq
// PURPOSE
//  Fetch sequencer: drives the fetch side of letc_core_imss_if (stage modport). Generates sequential
//  fetch addresses, caps in-flight IMSS requests by credit, buffers in-order responses in a small
//  FIFO for decode (valid/ready), and on redirect squashes stale in-flight responses.
//  Sits between the core's PC/redirect logic and the instruction memory subsystem.
// PARAMETERS
//  DEPTH     4             max (in-flight requests + buffered entries); FIFO depth; >=2
//  RESET_PC  32'h00000000  first fetch address after reset
// PORTS
//  clk             in   1    core clock; all state on rising edge
//  rst             in   1    asynchronous, active-high reset
//  i_redirect      in   1    redirect fetch (branch/trap/flush) this cycle
//  i_redirect_pc   in   32   new fetch address; bits[1:0] must be 0
//  imss            if   -    letc_core_imss_if.stage (req_valid, req_virtual_addr, rsp_*)
//  o_valid         out  1    buffered fetch entry available for decode
//  o_pc            out  32   virtual address of head entry
//  o_instr         out  32   instruction word of head entry
//  o_illegal       out  1    head entry's fetch faulted (rsp_illegal)
//  i_ready         in   1    decode accepts head entry when o_valid & i_ready
// BEHAVIOUR
//  Clocking: one clock; reset is asynchronous and active-high.
//  Reset: pc=RESET_PC, outstanding=0, squash=0, FIFO empty, state=FETCH; hence req_valid=0 during
//   reset, o_valid=0, o_pc/o_instr/o_illegal=0.
//  Counters: outstanding, squash in [0,DEPTH], width $clog2(DEPTH+1); invariant squash<=outstanding.
//  Issue (combinational): req_valid = state==FETCH & !i_redirect & (outstanding+fifo_count)<DEPTH;
//   req_virtual_addr = pc. IMSS has no backpressure: every req_valid cycle is one accepted request.
//   On issue: pc <= pc+4 (mod 2^32, 32'hFFFFFFFC wraps to 0); outstanding++.
//  Response (rsp_valid, strictly in request order, >=1 cycle after request): outstanding--.
//   squash>0 -> drop, squash--. else push {rsp_virtual_addr, rsp_data, rsp_illegal} to FIFO.
//   Credit rule guarantees push never hits a full FIFO.
//  Issue and response in same cycle: outstanding unchanged (net).
//  Output: head-of-FIFO registered; min latency rsp_valid -> o_valid = 1 cycle; no bypass.
//   Pop on o_valid & i_ready; push+pop same cycle allowed, count unchanged.
//  FSM states: FETCH (issuing), HALT (no issue).
//   FETCH -> HALT when a non-squashed response with rsp_illegal=1 is pushed; same edge
//    squash <= outstanding_next (all younger in-flight fetches discarded). Faulting entry still
//    delivered to decode with o_illegal=1.
//   HALT -> FETCH only on i_redirect. HALT holds pc; FIFO keeps draining to decode.
//  Redirect (highest priority): pc <= i_redirect_pc; FIFO flushed (any same-cycle push/pop
//   discarded, o_valid=0 next cycle); squash <= outstanding_next (outstanding minus 1 if rsp_valid
//   this cycle, squashed or not); state <= FETCH; no issue this cycle; first new request next cycle.
//  Back-to-back redirects: each recomputes squash; no stale response ever reaches o_valid.
//  Reset mid-operation: all state cleared immediately; responses after reset deassertion with
//   outstanding==0 are protocol errors.
//  SIMULATION assertions: no rsp_valid when outstanding==0; non-squashed rsp_virtual_addr equals
//   address of oldest live request; squash<=outstanding; no FIFO overflow/underflow.
// STRUCTURE
//  letc_core_pkg: fetch_entry_t packed struct {word_t pc; word_t instr; logic illegal};
//   fetch_state_e enum {FETCH, HALT}. word_t from riscv_pkg.
//  One sub-module: letc_core_fetch_fifo (sync FIFO of fetch_entry_t, DEPTH entries, ptr wrap,
//   count output, flush input); sequencer holds pc, counters, FSM.
// TESTING
//  Reset, IMSS 1-cycle latency, i_ready=1 -> req addrs 0,4,8,...; o_pc 0,4,8 one entry/cycle after fill.
//  DEPTH=4, i_ready=0, IMSS answers all -> exactly 4 requests issued, req_valid stays 0, FIFO full.
//  3 in flight, i_redirect to 32'h1000 -> 3 responses dropped, next o_pc=32'h1000, no 0x..C leak.
//  Response at addr 8 with rsp_illegal=1 -> o_illegal=1 at o_pc=8, later in-flight dropped, HALT
//   until redirect to 32'h200 resumes fetch at 32'h200.
//  RESET_PC=32'hFFFFFFF8 -> req addrs FFFFFFF8, FFFFFFFC, 00000000.
//  Redirect same cycle as rsp_valid and pop -> FIFO empty next cycle, squash=outstanding-1.

Source files
------------

// File: rtl/letc_core_pkg.sv
// ----------------------------------------------------------------------------
// letc_core_pkg
// Core-level types used by the fetch path: the buffered fetch entry handed to
// decode and the fetch sequencer state encoding.
// No ports (package).
// ----------------------------------------------------------------------------
package letc_core_pkg;

    typedef riscv_pkg::word_t word_t;

    // One decoded-side fetch slot: where it came from, what came back, and
    // whether the memory subsystem flagged the access as faulting.
    typedef struct packed {
        word_t pc;
        word_t instr;
        logic  illegal;
    } fetch_entry_t;

    typedef enum logic {
        FETCH = 1'b0,   // issuing sequential requests
        HALT  = 1'b1    // a fault was delivered; wait for a redirect
    } fetch_state_e;

    localparam word_t FETCH_STRIDE = 32'd4;

endpackage : letc_core_pkg

// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
// Basic RV32 types shared across the core.
// No ports (package).
// ----------------------------------------------------------------------------
package riscv_pkg;

    typedef logic [31:0] word_t;

endpackage : riscv_pkg

// File: rtl/letc_core_imss_if.sv
// ----------------------------------------------------------------------------
// letc_core_imss_if
// Request/response channel between a fetch stage and the instruction memory
// subsystem. Requests carry no ready: every cycle with req_valid=1 is one
// accepted request. Responses return strictly in request order, at least one
// cycle after their request, qualified by rsp_valid.
//   stage modport : drives req_*, receives rsp_*
//   mem   modport : receives req_*, drives rsp_*
// ----------------------------------------------------------------------------
interface letc_core_imss_if;
    import riscv_pkg::*;

    logic  req_valid;
    word_t req_virtual_addr;
    logic  rsp_valid;
    word_t rsp_virtual_addr;
    word_t rsp_data;
    logic  rsp_illegal;

    modport stage (
        output req_valid,
        output req_virtual_addr,
        input  rsp_valid,
        input  rsp_virtual_addr,
        input  rsp_data,
        input  rsp_illegal
    );

    modport mem (
        input  req_valid,
        input  req_virtual_addr,
        output rsp_valid,
        output rsp_virtual_addr,
        output rsp_data,
        output rsp_illegal
    );

endinterface : letc_core_imss_if

// File: rtl/letc_core_fetch_fifo.sv
// ----------------------------------------------------------------------------
// letc_core_fetch_fifo
// Synchronous FIFO of fetch_entry_t with DEPTH entries. Head is read straight
// from storage (registered), so an entry is visible the cycle after its push.
// Flush empties the FIFO and wins over any same-cycle push or pop.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   flush_i      : discard all entries (and this cycle's push/pop)
//   push_i       : write push_data_i at the tail
//   push_data_i  : entry to write
//   pop_i        : remove the head entry
//   head_o       : head entry (meaningful only when count_o != 0)
//   count_o      : number of stored entries, 0..DEPTH
// ----------------------------------------------------------------------------
module letc_core_fetch_fifo
    import letc_core_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  fetch_entry_t                 push_data_i,
    input  logic                         pop_i,
    output fetch_entry_t                 head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic do_push;
    logic do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i  && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (do_push && !do_pop) count_d = count_q + CNT_ONE;
            if (!do_push && do_pop) count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing reads it while count is zero.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (do_push && !do_pop) |-> (32'(count_q) < DEPTH));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        do_pop |-> (count_q != '0));

endmodule : letc_core_fetch_fifo

// File: rtl/letc_core_fetch_seq.sv
// ----------------------------------------------------------------------------
// letc_core_fetch_seq
// Fetch sequencer. Issues sequential fetch addresses to the instruction memory
// subsystem, limits requests so that in-flight + buffered never exceeds DEPTH,
// buffers in-order responses for decode, and discards responses that belong
// to a stream abandoned by a redirect or by a delivered fault.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   i_redirect      : restart fetch at i_redirect_pc (highest priority)
//   i_redirect_pc   : new fetch address, word aligned
//   imss            : stage side of the IMSS channel
//   o_valid/i_ready : decode handshake. An entry transfers on a rising edge
//                     where o_valid && i_ready; o_valid never depends on
//                     i_ready and the head holds steady until it transfers
//                     or a redirect flushes it.
//   o_pc, o_instr   : head entry address / instruction word (0 when empty)
//   o_illegal       : head entry faulted (0 when empty)
// ----------------------------------------------------------------------------
module letc_core_fetch_seq
    import letc_core_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter word_t       RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_redirect,
    input  word_t           i_redirect_pc,
    letc_core_imss_if.stage imss,
    output logic            o_valid,
    output word_t           o_pc,
    output word_t           o_instr,
    output logic            o_illegal,
    input  logic            i_ready
);

    localparam int unsigned   CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    fetch_state_e  state_q, state_d;
    word_t         pc_q, pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] squash_q, squash_d;
    // Address the next live response must carry; only feeds an assertion.
    word_t         exp_rsp_addr_q, exp_rsp_addr_d;

    logic          issue;
    logic          rsp_live;
    logic          rsp_drop;
    logic [CW-1:0] outstanding_nx;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_flush;
    fetch_entry_t  rsp_entry;
    fetch_entry_t  fifo_head;
    logic [CW-1:0] fifo_count;

    // Credit: a request may only go out if its response is guaranteed a slot.
    assign issue = !rst && (state_q == FETCH) && !i_redirect &&
                   ((32'(outstanding_q) + 32'(fifo_count)) < DEPTH);

    assign rsp_live = imss.rsp_valid && (squash_q == '0);
    assign rsp_drop = imss.rsp_valid && (squash_q != '0);

    assign imss.req_valid        = issue;
    assign imss.req_virtual_addr = pc_q;

    assign rsp_entry = '{pc: imss.rsp_virtual_addr,
                         instr: imss.rsp_data,
                         illegal: imss.rsp_illegal};

    // In-flight count after this edge; every stale-stream squash is sized from it.
    always_comb begin
        outstanding_nx = outstanding_q;
        if (issue && !imss.rsp_valid) outstanding_nx = outstanding_q + CNT_ONE;
        if (!issue && imss.rsp_valid) outstanding_nx = outstanding_q - CNT_ONE;
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        outstanding_d  = outstanding_nx;
        squash_d       = squash_q;
        exp_rsp_addr_d = exp_rsp_addr_q;
        fifo_push      = rsp_live;
        fifo_pop       = o_valid && i_ready;
        fifo_flush     = 1'b0;

        if (issue) pc_d = pc_q + FETCH_STRIDE;

        if (rsp_drop) squash_d = squash_q - CNT_ONE;

        if (rsp_live) begin
            exp_rsp_addr_d = exp_rsp_addr_q + FETCH_STRIDE;
            // The faulting entry still goes to decode; everything younger,
            // including a request issued this same cycle, is discarded.
            if (imss.rsp_illegal) begin
                state_d  = HALT;
                squash_d = outstanding_nx;
            end
        end

        if (i_redirect) begin
            state_d        = FETCH;
            pc_d           = i_redirect_pc;
            squash_d       = outstanding_nx;
            exp_rsp_addr_d = i_redirect_pc;
            fifo_push      = 1'b0;
            fifo_pop       = 1'b0;
            fifo_flush     = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= FETCH;
            pc_q           <= RESET_PC;
            outstanding_q  <= '0;
            squash_q       <= '0;
            exp_rsp_addr_q <= RESET_PC;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            outstanding_q  <= outstanding_d;
            squash_q       <= squash_d;
            exp_rsp_addr_q <= exp_rsp_addr_d;
        end
    end

    letc_core_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (fifo_flush),
        .push_i      (fifo_push),
        .push_data_i (rsp_entry),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

    assign o_valid   = (fifo_count != '0);
    assign o_pc      = o_valid ? fifo_head.pc      : '0;
    assign o_instr   = o_valid ? fifo_head.instr   : '0;
    assign o_illegal = o_valid ? fifo_head.illegal : 1'b0;

    a_rsp_needs_request: assert property (@(posedge clk) disable iff (rst)
        imss.rsp_valid |-> (outstanding_q != '0));
    a_rsp_in_order: assert property (@(posedge clk) disable iff (rst)
        rsp_live |-> (imss.rsp_virtual_addr == exp_rsp_addr_q));
    a_squash_bounded: assert property (@(posedge clk) disable iff (rst)
        squash_q <= outstanding_q);

endmodule : letc_core_fetch_seq

// File: tb/tb_letc_core_fetch_seq.sv
module tb_letc_core_fetch_seq;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        i_ready;
  logic        o_valid;
  logic [31:0] o_pc;
  logic [31:0] o_instr;
  logic        o_illegal;

  letc_core_imss_if imss_bus ();

  letc_core_fetch_seq #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .imss          (imss_bus),
    .o_valid       (o_valid),
    .o_pc          (o_pc),
    .o_instr       (o_instr),
    .o_illegal     (o_illegal),
    .i_ready       (i_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // A request in the memory subsystem: live means its stream is still wanted.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        ill;
    logic        live;
    logic [31:0] cyc;
  } pend_t;

  pend_t       pend_q[$];     // requests accepted by IMSS, oldest first
  logic [64:0] exp_q[$];      // entries decode should see: {pc, instr, illegal}
  logic [31:0] model_pc;
  logic        halted;
  logic [31:0] cyc;
  logic [31:0] ill_addr;      // a request to this address comes back faulting
  int          ill_permille;

  int n_checks;
  int n_errors;

  task automatic chk(input string tag, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_init();
    pend_q.delete();
    exp_q.delete();
    model_pc = RESET_PC;
    halted   = 1'b0;
  endtask

  task automatic check_outputs();
    logic [64:0] head;
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      chk("o_valid",   65'(o_valid),   65'(1'b1));
      chk("o_pc",      65'(o_pc),      65'(head[64:33]));
      chk("o_instr",   65'(o_instr),   65'(head[32:1]));
      chk("o_illegal", 65'(o_illegal), 65'(head[0]));
    end else begin
      chk("o_valid_idle", 65'(o_valid), 65'(1'b0));
      chk("o_pc_idle",    65'(o_pc),    65'(0));
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: checks registered outputs, drives inputs for the
  // coming rising edge, checks the request side, advances the model, and
  // returns at the next falling edge.
  task automatic step(input logic redir, input logic [31:0] rpc, input logic ready,
                      input int unsigned rsp_pct);
    logic  fire;
    logic  exp_req;
    pend_t e;
    check_outputs();
    fire = 1'b0;
    if (pend_q.size() != 0)
      if (pend_q[0].cyc < cyc && $urandom_range(0, 99) < rsp_pct) fire = 1'b1;
    i_redirect    = redir;
    i_redirect_pc = rpc;
    i_ready       = ready;
    imss_bus.rsp_valid = fire;
    if (fire) begin
      e = pend_q[0];
      imss_bus.rsp_virtual_addr = e.addr;
      imss_bus.rsp_data         = e.data;
      imss_bus.rsp_illegal      = e.ill;
    end else begin
      imss_bus.rsp_virtual_addr = $urandom;
      imss_bus.rsp_data         = $urandom;
      imss_bus.rsp_illegal      = 1'($urandom_range(0, 1));
    end
    #1;
    exp_req = !halted && !redir && ((pend_q.size() + exp_q.size()) < DEPTH);
    chk("req_valid", 65'(imss_bus.req_valid), 65'(exp_req));
    if (exp_req) chk("req_addr", 65'(imss_bus.req_virtual_addr), 65'(model_pc));

    if (exp_q.size() != 0 && ready && !redir) void'(exp_q.pop_front());
    if (exp_req) begin
      e.addr = model_pc;
      e.data = $urandom;
      e.ill  = (model_pc == ill_addr) || ($urandom_range(0, 999) < ill_permille);
      e.live = 1'b1;
      e.cyc  = cyc;
      pend_q.push_back(e);
      model_pc = model_pc + 32'd4;
    end
    if (fire) begin
      e = pend_q.pop_front();
      if (e.live && !redir) begin
        exp_q.push_back({e.addr, e.data, e.ill});
        if (e.ill) begin
          halted = 1'b1;
          foreach (pend_q[i]) pend_q[i].live = 1'b0;
        end
      end
    end
    if (redir) begin
      foreach (pend_q[i]) pend_q[i].live = 1'b0;
      exp_q.delete();
      model_pc = rpc;
      halted   = 1'b0;
    end
    cyc = cyc + 32'd1;
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic ready, input int unsigned rsp_pct);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, ready, rsp_pct);
  endtask

  // Reset asserted asynchronously mid-cycle; outputs must clear at once.
  task automatic mid_reset();
    imss_bus.rsp_valid = 1'b0;
    i_redirect = 1'b0;
    i_ready    = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mrst_o_valid",   65'(o_valid),            65'(1'b0));
    chk("mrst_o_pc",      65'(o_pc),               65'(0));
    chk("mrst_req_valid", 65'(imss_bus.req_valid), 65'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    model_init();
  endtask

  // ---------------- scenario ----------------
  initial begin
    logic [31:0] r;
    n_checks = 0;
    n_errors = 0;
    cyc = 0;
    ill_addr = 32'h1;      // unaligned: never matches a request
    ill_permille = 0;
    rst = 1'b1;
    i_redirect = 1'b0;
    i_redirect_pc = '0;
    i_ready = 1'b0;
    imss_bus.rsp_valid = 1'b0;
    imss_bus.rsp_virtual_addr = '0;
    imss_bus.rsp_data = '0;
    imss_bus.rsp_illegal = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_valid", 65'(imss_bus.req_valid), 65'(1'b0));
    chk("rst_o_valid",   65'(o_valid),   65'(1'b0));
    chk("rst_o_pc",      65'(o_pc),      65'(0));
    chk("rst_o_instr",   65'(o_instr),   65'(0));
    chk("rst_o_illegal", 65'(o_illegal), 65'(1'b0));
    rst = 1'b0;
    model_init();

    // Streaming from RESET_PC across the address wrap, 1-cycle IMSS latency.
    run(20, 1'b1, 100);
    // Decode stalled: fetch must stop once in-flight + buffered reaches DEPTH.
    run(12, 1'b0, 100);
    run(8, 1'b1, 100);
    // Several requests in flight, then redirect: all of them must vanish.
    run(4, 1'b1, 0);
    step(1'b1, 32'h0000_1000, 1'b1, 0);
    run(15, 1'b1, 100);
    // Fault at address 8: delivered, younger fetches dropped, halt until redirect.
    ill_addr = 32'h8;
    step(1'b1, 32'h0, 1'b1, 0);
    run(25, 1'b1, 60);
    ill_addr = 32'h1;
    step(1'b1, 32'h0000_0200, 1'b1, 0);
    run(15, 1'b1, 100);
    // Redirect coinciding with a response and a pop.
    run(4, 1'b0, 100);
    step(1'b1, 32'h0000_0300, 1'b1, 100);
    run(10, 1'b1, 100);
    // Reset in the middle of traffic.
    run(3, 1'b1, 50);
    mid_reset();
    run(10, 1'b1, 100);

    // Random traffic: redirects, stalls, variable latency, occasional faults.
    ill_permille = 20;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) < 3) begin
        r = $urandom;
        if ($urandom_range(0, 3) == 0) r = 32'hFFFF_FFF0;
        step(1'b1, {r[31:2], 2'b00}, 1'($urandom_range(0, 99) < 70), $urandom_range(20, 100));
      end else begin
        step(1'b0, 32'h0, 1'($urandom_range(0, 99) < 70), $urandom_range(20, 100));
      end
    end

    // Drain.
    ill_permille = 0;
    step(1'b1, 32'h0000_4000, 1'b1, 100);
    run(40, 1'b1, 100);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_letc_core_fetch_seq
